// File: rtl/usb_buffer_pkg.sv
// Shared types and constants for the USB byte-to-word ingress buffer.
package usb_buffer_pkg;
    localparam int DEPTH_DEFAULT  = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/usb_buffer_if.sv
// Internal bus between the word-pop control and the byte FIFO storage.
interface usb_buffer_if #(
    parameter int DEPTH = usb_buffer_pkg::DEPTH_DEFAULT
) ();
    import usb_buffer_pkg::*;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    byte_t            wr_data;
    logic             wr_en;
    logic             rd_en;
    word_t            rd_word;
    logic [CNT_W-1:0] count;

    modport master (output wr_data, wr_en, rd_en, input rd_word, count);
    modport slave  (input wr_data, wr_en, rd_en, output rd_word, count);
endinterface

// File: rtl/usb_byte_fifo.sv
// Byte FIFO with a single-byte write port and a 4-byte parallel read port.
module usb_byte_fifo
    import usb_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    usb_buffer_if.slave fifo_bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    byte_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    word_t            w_rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (fifo_bus.wr_en)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (fifo_bus.rd_en)
                r_rd_ptr <= r_rd_ptr + PTR_W'(BYTES_PER_WORD);
            r_count <= r_count + CNT_W'(fifo_bus.wr_en)
                       - (fifo_bus.rd_en ? CNT_W'(BYTES_PER_WORD) : CNT_W'(0));
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && fifo_bus.wr_en)
            r_mem[r_wr_ptr] <= fifo_bus.wr_data;
    end

    // Oldest byte lands in the top lane; pointer arithmetic wraps naturally.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++)
            w_rd_word[(WORD_W-1-BYTE_W*i) -: BYTE_W] = r_mem[r_rd_ptr + PTR_W'(i)];
    end

    assign fifo_bus.rd_word = w_rd_word;
    assign fifo_bus.count   = r_count;
endmodule

// File: rtl/usb_buffer.sv
// USB ingress elastic buffer: captures a byte every clock, releases 32-bit words on pop.
module usb_buffer
    import usb_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    output word_t            shiftOut,
    input  byte_t            shiftIn,
    input  logic             clk,
    input  logic             pop,
    input  logic             rst,
    output logic [CNT_W-1:0] count,
    output logic             word_avail,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    usb_buffer_if #(.DEPTH(DEPTH)) fifo_bus ();

    word_t r_shift_out;
    logic  r_overflow;
    logic  r_underflow;
    logic  w_pop_ok;
    logic  w_push_ok;

    assign count      = fifo_bus.count;
    assign word_avail = count >= CNT_W'(BYTES_PER_WORD);
    assign full       = count == CNT_W'(DEPTH);

    // A same-cycle accepted pop frees space, so a full FIFO can still take the byte.
    assign w_pop_ok  = pop && word_avail;
    assign w_push_ok = !full || w_pop_ok;

    assign fifo_bus.wr_data = shiftIn;
    assign fifo_bus.wr_en   = w_push_ok;
    assign fifo_bus.rd_en   = w_pop_ok;

    usb_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .fifo_bus (fifo_bus)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_out <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop_ok)
                r_shift_out <= fifo_bus.rd_word;
            if (!w_push_ok)
                r_overflow <= 1'b1;
            if (pop && !word_avail)
                r_underflow <= 1'b1;
        end
    end

    assign shiftOut  = r_shift_out;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
endmodule

// File: tb/tb_usb_buffer.sv
// Randomized self-checking bench for usb_buffer against a queue-based reference model.
module tb_usb_buffer;
    import usb_buffer_pkg::*;

    localparam int DEPTH = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    word_t            shift_out;
    logic [CNT_W-1:0] count;
    logic             word_avail;
    logic             full;
    logic             overflow;
    logic             underflow;

    usb_buffer_if #(.DEPTH(DEPTH)) tb_bus ();

    assign tb_bus.wr_en   = ~rst;
    assign tb_bus.rd_word = shift_out;
    assign tb_bus.count   = count;

    usb_buffer #(.DEPTH(DEPTH)) dut (
        .shiftOut   (shift_out),
        .shiftIn    (tb_bus.wr_data),
        .clk        (clk),
        .pop        (tb_bus.rd_en),
        .rst        (rst),
        .count      (count),
        .word_avail (word_avail),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus the last popped word and sticky flags.
    byte_t m_q[$];
    word_t m_word;
    logic  m_ovf;
    logic  m_unf;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic byte_t rotl8(input byte_t b, input int n);
        byte_t r;
        r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Drive one clock with the given byte/pop, update the model, return at the next negedge.
    task automatic cycle(input byte_t b, input logic p);
        tb_bus.wr_data = b;
        tb_bus.rd_en   = p;
        @(posedge clk);
        if (p && m_q.size() >= BYTES_PER_WORD) begin
            m_word = {m_q[0], m_q[1], m_q[2], m_q[3]};
            repeat (BYTES_PER_WORD) void'(m_q.pop_front());
        end else if (p) begin
            m_unf = 1'b1;
        end
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else                    m_ovf = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        tb_bus.wr_data = byte_t'($urandom);
        tb_bus.rd_en   = 1'($urandom);
        @(posedge clk);
        m_q.delete();
        m_word = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++;
        if (shift_out !== '0) $display("FAIL reset_shiftout: got %h want 0", shift_out); else n_pass++;
        n_checks++;
        if ({word_avail, full, overflow, underflow} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {word_avail, full, overflow, underflow});
        else n_pass++;
    endtask

    task automatic test_basic_word();
        do_reset();
        cycle(8'h01, 1'b0);
        cycle(8'h02, 1'b0);
        cycle(8'h04, 1'b0);
        cycle(8'h08, 1'b0);
        n_checks++;
        if (count !== 6'd4 || word_avail !== 1'b1)
            $display("FAIL basic_fill: got count=%0d avail=%b want count=4 avail=1", count, word_avail);
        else n_pass++;
        cycle(byte_t'($urandom), 1'b1);
        n_checks++;
        if (shift_out !== 32'h01020408) $display("FAIL basic_word: got %h want 01020408", shift_out); else n_pass++;
        n_checks++;
        if (count !== CNT_W'(m_q.size())) $display("FAIL basic_count: got %0d want %0d", count, m_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        byte_t base;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            case (i / 8)
                0:       base = 8'h01;
                1:       base = 8'h03;
                default: base = 8'h0F;
            endcase
            cycle(rotl8(base, i % 8), 1'b0);
        end
        n_checks++;
        if (count !== 6'd24 || full !== 1'b0)
            $display("FAIL stream_fill: got count=%0d full=%b want count=24 full=0", count, full);
        else n_pass++;
        for (int w = 0; w < 6; w++) begin
            cycle(byte_t'($urandom), 1'b1);
            n_checks++;
            if (shift_out !== m_word || count !== CNT_W'(m_q.size()))
                $display("FAIL stream_pop%0d: got word=%h count=%0d want word=%h count=%0d",
                         w, shift_out, count, m_word, m_q.size());
            else n_pass++;
        end
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL stream_flags: got ovf=%b unf=%b want 0 0", overflow, underflow);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(byte_t'($urandom), 1'b0);
        n_checks++;
        if (full !== 1'b1 || count !== CNT_W'(DEPTH) || overflow !== 1'b0)
            $display("FAIL ovf_full: got full=%b count=%0d ovf=%b want 1 %0d 0", full, count, overflow, DEPTH);
        else n_pass++;
        cycle(byte_t'($urandom), 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || count !== CNT_W'(DEPTH))
            $display("FAIL ovf_drop: got ovf=%b count=%0d want 1 %0d", overflow, count, DEPTH);
        else n_pass++;
        cycle(byte_t'($urandom), 1'b1);
        n_checks++;
        if (shift_out !== m_word) $display("FAIL ovf_first_word: got %h want %h", shift_out, m_word); else n_pass++;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(byte_t'($urandom), 1'b0);
        cycle(byte_t'($urandom), 1'b1);
        n_checks++;
        if (shift_out !== m_word || shift_out !== 32'h0)
            $display("FAIL unf_hold: got %h want %h", shift_out, m_word);
        else n_pass++;
        n_checks++;
        if (underflow !== 1'b1 || count !== 6'd4)
            $display("FAIL unf_flag: got unf=%b count=%0d want 1 4", underflow, count);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(byte_t'($urandom), 1'b0);
        cycle(byte_t'($urandom), 1'b1);
        n_checks++;
        if (count !== 6'd29 || overflow !== 1'b0)
            $display("FAIL fullpop: got count=%0d ovf=%b want 29 0", count, overflow);
        else n_pass++;
        n_checks++;
        if (shift_out !== m_word) $display("FAIL fullpop_word: got %h want %h", shift_out, m_word); else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        int errs;
        byte_t first;
        do_reset();
        for (int i = 0; i < 30; i++) cycle(byte_t'($urandom), 1'b0);
        errs = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(byte_t'($urandom), ($urandom_range(0, 3) != 0));
            n_checks++;
            if (shift_out !== m_word || count !== CNT_W'(m_q.size()) ||
                full !== (m_q.size() == DEPTH) || word_avail !== (m_q.size() >= BYTES_PER_WORD) ||
                overflow !== m_ovf || underflow !== m_unf) begin
                if (errs < 5)
                    $display("FAIL wrap_cycle%0d: got word=%h count=%0d ovf=%b unf=%b want word=%h count=%0d ovf=%b unf=%b",
                             i, shift_out, count, overflow, underflow, m_word, m_q.size(), m_ovf, m_unf);
                errs++;
            end else n_pass++;
        end
        do_reset();
        n_checks++;
        if (count !== '0 || shift_out !== '0 || overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL midreset: got count=%0d word=%h ovf=%b unf=%b want all 0",
                     count, shift_out, overflow, underflow);
        else n_pass++;
        first = byte_t'($urandom);
        cycle(first, 1'b0);
        for (int i = 0; i < 3; i++) cycle(byte_t'($urandom), 1'b0);
        cycle(byte_t'($urandom), 1'b1);
        n_checks++;
        if (shift_out[31:24] !== first || shift_out !== m_word)
            $display("FAIL postreset_word: got %h want %h", shift_out, m_word);
        else n_pass++;
    endtask

    initial begin
        rst            = 1'b1;
        tb_bus.wr_data = '0;
        tb_bus.rd_en   = 1'b0;
        m_word         = '0;
        m_ovf          = 1'b0;
        m_unf          = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_word();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_full_pop();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
